alu4bit_arbiter: RTL and testbench

//  Shares one combinational 4-bit ALU (opcodes ADD..XNOR) between two requesters.
//  - Round-robin arbitration; operands and opcode latched on accept.
//  - Drives the ALU ports for one EXEC cycle and registers the 5-bit result.
//  - Returns the result with the winning requester ID over a valid/ready response channel.
//  - Sits between the two issuing units and the ALU instance.

---
 rtl/alu4bit_pkg.sv | 27 ++
 rtl/alu4bit_arbiter_if.sv | 39 +++
 rtl/alu4bit_arbiter_rr_arb2.sv | 34 +++
 rtl/alu4bit_arbiter.sv | 129 ++++++++++++
 tb/tb_alu4bit_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu4bit_pkg.sv
// Shared definitions for the 4-bit ALU arbiter: opcode map, legal opcode range and FSM states.
// Optional feature macro used by the slice: ALU_ARB_ZERO_FLAG_EN.
package alu4bit_pkg;

  localparam int OP_ADD  = 3;
  localparam int OP_SUB  = 4;
  localparam int OP_AND  = 5;
  localparam int OP_NAND = 6;
  localparam int OP_OR   = 7;
  localparam int OP_NOR  = 8;
  localparam int OP_XOR  = 9;
  localparam int OP_XNOR = 10;

  localparam int OP_MIN = OP_ADD;
  localparam int OP_MAX = OP_XNOR;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_is_illegal(input int unsigned op);
    return (op < OP_MIN) || (op > OP_MAX);
  endfunction

endpackage

// File: rtl/alu4bit_arbiter_if.sv
// Request/response bundle between the two issuing units, the response consumer and the arbiter.
// Macro ALU_ARB_ZERO_FLAG_EN adds the rsp_zero flag to the response channel.
interface alu4bit_arbiter_if #(
  parameter int DW  = 4,
  parameter int OPW = 4
);

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2*OPW-1:0] req_op;
  logic [2*DW-1:0]  req_a;
  logic [2*DW-1:0]  req_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW:0]      rsp_data;
  logic             rsp_id;
  logic             rsp_illegal;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic             rsp_zero;
`endif

  modport master (
`ifdef ALU_ARB_ZERO_FLAG_EN
    input  rsp_zero,
`endif
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_illegal
  );

  modport slave (
`ifdef ALU_ARB_ZERO_FLAG_EN
    output rsp_zero,
`endif
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_illegal
  );

endinterface

// File: rtl/alu4bit_arbiter_rr_arb2.sv
// Two-way round-robin grant with its priority pointer; the pointer only moves when the
// owner enables it, and then hands priority to the requester that was not granted.
module rr_arb2 #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       update_en,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr_reg;
  logic ptr_next;

  always_comb begin
    grant_id = valid[ptr_reg] ? ptr_reg : ~ptr_reg;
    ptr_next = update_en ? ~grant_id : ptr_reg;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant[gi] = (|valid) && (grant_id == 1'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= RR_INIT;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/alu4bit_arbiter.sv
// Shares one external combinational 4-bit ALU between two requesters: IDLE accept, one EXEC
// cycle on the ALU ports, RESP hold. Macro ALU_ARB_ZERO_FLAG_EN adds the registered rsp_zero flag.
module alu4bit_arbiter
  import alu4bit_pkg::*;
#(
  parameter int DW      = 4,
  parameter int OPW     = 4,
  parameter int RR_INIT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  alu4bit_arbiter_if.slave    bus,
  output logic [OPW-1:0]      alu_opcode,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  input  logic [DW:0]         alu_result
);

  state_t           state_reg;
  state_t           state_next;
  logic [OPW-1:0]   op_reg;
  logic [DW-1:0]    a_reg;
  logic [DW-1:0]    b_reg;
  logic             id_reg;
  logic [DW:0]      data_reg;
  logic             illegal_reg;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic             zero_reg;
`endif

  logic [1:0]       grant;
  logic             grant_id;
  logic             accept;
  logic             exec_illegal;
  logic [OPW-1:0]   op_slot [2];
  logic [DW-1:0]    a_slot  [2];
  logic [DW-1:0]    b_slot  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    assign op_slot[gi] = bus.req_op[gi*OPW +: OPW];
    assign a_slot[gi]  = bus.req_a[gi*DW +: DW];
    assign b_slot[gi]  = bus.req_b[gi*DW +: DW];
  end

  rr_arb2 #(
    .RR_INIT (1'(RR_INIT))
  ) u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (bus.req_valid),
    .update_en (accept),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  assign exec_illegal = op_is_illegal(32'(op_reg));

  always_comb begin
    state_next    = state_reg;
    accept        = 1'b0;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 1'b0;
    alu_opcode    = '0;
    alu_a         = '0;
    alu_b         = '0;
    case (state_reg)
      ST_IDLE: begin
        // grant is already qualified by req_valid, so any grant bit is a handshake
        bus.req_ready = grant;
        if (|grant) begin
          accept     = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_opcode = op_reg;
        alu_a      = a_reg;
        alu_b      = b_reg;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      id_reg      <= 1'b0;
      data_reg    <= '0;
      illegal_reg <= 1'b0;
`ifdef ALU_ARB_ZERO_FLAG_EN
      zero_reg    <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg <= op_slot[grant_id];
        a_reg  <= a_slot[grant_id];
        b_reg  <= b_slot[grant_id];
        id_reg <= grant_id;
      end
      // the full DW+1 ALU result is kept so carries and SUB borrows survive
      if (state_reg == ST_EXEC) begin
        data_reg    <= exec_illegal ? '0 : alu_result;
        illegal_reg <= exec_illegal;
`ifdef ALU_ARB_ZERO_FLAG_EN
        zero_reg    <= exec_illegal || (alu_result == '0);
`endif
      end
    end
  end

  assign bus.rsp_data    = data_reg;
  assign bus.rsp_id      = id_reg;
  assign bus.rsp_illegal = illegal_reg;
`ifdef ALU_ARB_ZERO_FLAG_EN
  assign bus.rsp_zero    = zero_reg;
`endif

endmodule

// File: tb/tb_alu4bit_arbiter.sv
// Self-checking bench for alu4bit_arbiter: provides the external ALU, drives both requesters
// and checks against a round-robin/arithmetic reference. Honours ALU_ARB_ZERO_FLAG_EN.
module tb_alu4bit_arbiter;

  localparam int DW  = 4;
  localparam int OPW = 4;
  localparam int RR  = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_result;

  int total = 0;
  int bad   = 0;
  int ptr   = RR;

  always #5 clk = ~clk;

  alu4bit_arbiter_if #(.DW(DW), .OPW(OPW)) bus ();

  alu4bit_arbiter #(
    .DW      (DW),
    .OPW     (OPW),
    .RR_INIT (RR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  // External ALU; unknown opcodes return a non-zero pattern so forcing to 0 is visible
  function automatic logic [4:0] alu_model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      4'd3:    return {1'b0, a} + {1'b0, b};
      4'd4:    return {1'b0, a} - {1'b0, b};
      4'd5:    return {1'b0, a & b};
      4'd6:    return {1'b0, ~(a & b)};
      4'd7:    return {1'b0, a | b};
      4'd8:    return {1'b0, ~(a | b)};
      4'd9:    return {1'b0, a ^ b};
      4'd10:   return {1'b0, ~(a ^ b)};
      default: return 5'h15;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_opcode, alu_a, alu_b);

  task automatic set_req(input int id, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.req_op[id*4 +: 4] = op;
    bus.req_a[id*4 +: 4]  = a;
    bus.req_b[id*4 +: 4]  = b;
  endtask

  task automatic randomize_reqs();
    for (int i = 0; i < 2; i++) begin
      set_req(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
  endtask

  // Entered at a negedge in IDLE; leaves at the negedge after the response handshake.
  task automatic run_op(input logic [1:0] valid, input int stall, output logic [4:0] got_data,
                        output logic got_id, output logic got_ill, output logic got_zero);
    int         gid;
    logic [3:0] op, a, b;
    logic [4:0] exp_data;
    logic       exp_ill;
    bus.req_valid = valid;
    bus.rsp_ready = 1'b0;
    #1;
    gid      = valid[ptr] ? ptr : 1 - ptr;
    op       = bus.req_op[gid*4 +: 4];
    a        = bus.req_a[gid*4 +: 4];
    b        = bus.req_b[gid*4 +: 4];
    exp_ill  = (op < 4'd3) || (op > 4'd10);
    exp_data = exp_ill ? 5'd0 : alu_model(op, a, b);
    total++;
    if (bus.req_ready !== 2'(1 << gid)) begin
      bad++;
      $display("FAIL grant: req_ready=%b want %b (valid=%b)", bus.req_ready, 2'(1 << gid), valid);
    end
    ptr = 1 - gid;
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.rsp_ready = (stall == 0);
    #1;
    total++;
    if ({alu_opcode, alu_a, alu_b, bus.rsp_valid, bus.req_ready} !== {op, a, b, 1'b0, 2'b00}) begin
      bad++;
      $display("FAIL exec: alu=%0d/%0d/%0d vld=%b rdy=%b want %0d/%0d/%0d 0 00",
               alu_opcode, alu_a, alu_b, bus.rsp_valid, bus.req_ready, op, a, b);
    end
    // rsp_valid must appear two negedges after the handshake was presented
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      if (s == stall) begin
        bus.rsp_ready = 1'b1;
        #1;
      end
      total++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_illegal, bus.req_ready, alu_opcode, alu_a, alu_b}
          !== {1'b1, 1'(gid), exp_data, exp_ill, 2'b00, 12'd0}) begin
        bad++;
        $display("FAIL resp[%0d]: vld=%b id=%b data=%h ill=%b rdy=%b alu=%h%h%h want 1 %0d %h %b 00 000",
                 s, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_illegal, bus.req_ready,
                 alu_opcode, alu_a, alu_b, gid, exp_data, exp_ill);
      end
`ifdef ALU_ARB_ZERO_FLAG_EN
      total++;
      if (bus.rsp_zero !== (exp_data == 5'd0)) begin
        bad++;
        $display("FAIL resp_zero: got %b want %b", bus.rsp_zero, (exp_data == 5'd0));
      end
`endif
    end
    got_data = bus.rsp_data;
    got_id   = bus.rsp_id;
    got_ill  = bus.rsp_illegal;
`ifdef ALU_ARB_ZERO_FLAG_EN
    got_zero = bus.rsp_zero;
`else
    got_zero = 1'b0;
`endif
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rsp_drop: rsp_valid=%b want 0", bus.rsp_valid);
    end
    bus.req_valid = 2'b00;
    $display("op id=%0d op=%0d a=%0d b=%0d stall=%0d -> data=%h ill=%b", gid, op, a, b, stall, got_data, got_ill);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr   = RR;
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_illegal, alu_opcode, alu_a, alu_b} !== 22'd0) begin
      bad++;
      $display("FAIL reset: outputs=%h want 0",
               {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_illegal, alu_opcode, alu_a, alu_b});
    end
`ifdef ALU_ARB_ZERO_FLAG_EN
    total++;
    if (bus.rsp_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_zero: rsp_zero=%b want 0", bus.rsp_zero);
    end
`endif
    rst_n = 1'b1;
    ptr   = RR;
    $display("reset released");
  endtask

  task automatic test_add();
    logic [4:0] d;
    logic       id, ill, z;
    set_req(0, 4'd3, 4'd9, 4'd8);
    run_op(2'b01, 0, d, id, ill, z);
    total++;
    if ({d, id, ill} !== {5'd17, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL add: data=%0d id=%b ill=%b want 17 0 0", d, id, ill);
    end
  endtask

  task automatic test_sub_stall();
    logic [4:0] d;
    logic       id, ill, z;
    set_req(1, 4'd4, 4'd2, 4'd5);
    run_op(2'b10, 4, d, id, ill, z);
    total++;
    if ({d, id, ill} !== {5'h1D, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sub_stall: data=%h id=%b ill=%b want 1d 1 0", d, id, ill);
    end
  endtask

  task automatic test_illegal();
    logic [4:0] d;
    logic       id, ill, z;
    set_req(0, 4'd12, 4'd7, 4'd3);
    run_op(2'b01, 0, d, id, ill, z);
    total++;
    if ({d, ill} !== {5'd0, 1'b1}) begin
      bad++;
      $display("FAIL illegal: data=%h ill=%b want 00 1", d, ill);
    end
`ifdef ALU_ARB_ZERO_FLAG_EN
    total++;
    if (z !== 1'b1) begin
      bad++;
      $display("FAIL illegal_zero: rsp_zero=%b want 1", z);
    end
`endif
  endtask

  task automatic test_xor_zero();
    logic [4:0] d;
    logic       id, ill, z;
    set_req(0, 4'd9, 4'd5, 4'd5);
    run_op(2'b01, 1, d, id, ill, z);
    total++;
    if ({d, ill} !== {5'd0, 1'b0}) begin
      bad++;
      $display("FAIL xor_zero: data=%h ill=%b want 00 0", d, ill);
    end
`ifdef ALU_ARB_ZERO_FLAG_EN
    total++;
    if (z !== 1'b1) begin
      bad++;
      $display("FAIL xor_zero_flag: rsp_zero=%b want 1", z);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [4:0] d;
    logic       id, ill, z;
    set_req(0, 4'd3, 4'd15, 4'd15);
    set_req(1, 4'd7, 4'd1, 4'd2);
    bus.req_valid = 2'b01;
    #1;
    total++;
    if (bus.req_ready !== 2'b01) begin
      bad++;
      $display("FAIL mid_grant: req_ready=%b want 01", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.rsp_valid, bus.rsp_data, alu_opcode, alu_a, alu_b} !== 18'd0) begin
      bad++;
      $display("FAIL mid_abort: vld=%b data=%h alu=%h%h%h want all 0",
               bus.rsp_valid, bus.rsp_data, alu_opcode, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ptr   = RR;
    total++;
    if (bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_lost: rsp_valid=%b want 0", bus.rsp_valid);
    end
    run_op(2'b11, 0, d, id, ill, z);
    total++;
    if (id !== 1'(RR)) begin
      bad++;
      $display("FAIL mid_ptr: rsp_id=%b want %0d", id, RR);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] d;
    logic       id, ill, z;
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      randomize_reqs();
      run_op(2'b11, 0, d, id, ill, z);
      total++;
      if (id !== 1'(RR ^ (i & 1))) begin
        bad++;
        $display("FAIL alternate[%0d]: rsp_id=%b want %0d", i, id, RR ^ (i & 1));
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] d;
    logic       id, ill, z;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req_valid = 2'b00;
        #1;
        total++;
        if (bus.req_ready !== 2'b00) begin
          bad++;
          $display("FAIL idle_ready: req_ready=%b want 00", bus.req_ready);
        end
        @(negedge clk);
      end
      randomize_reqs();
      run_op(2'($urandom_range(1, 3)), $urandom_range(0, 3), d, id, ill, z);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_stall();
    test_illegal();
    test_xor_zero();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
